// File: rtl/exc_sequencer.sv
// Exception/ERET sequencer for the five-stage core.
// Reacts to a CP0 request or a committing ERET. It flushes F/D/E/M and holds a
// PC redirect until fetch accepts it. A fixed-length drain window follows.
// Exceptions and interrupts taken are counted with saturating counters.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          DRAIN_CYC    = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic [4:0]       exc_code_m,
  input  logic             eret_m,
  input  logic             stall_in,
  input  logic [31:0]      epc_in,
  input  logic             fetch_ready,
  output logic             flush_fdem,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] exc_cnt,
  output logic [CNT_W-1:0] int_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_RET   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0]       LP_DRAIN = 4'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] LP_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_target;
  logic [3:0]       r_drain;
  logic [CNT_W-1:0] r_exc_cnt;
  logic [CNT_W-1:0] r_int_cnt;
  logic             w_flush;
  logic             w_take_req;
  logic             w_take_eret;
  logic             w_accept;

  // Next-state and flush decode. IDLE reacts to inputs in the same cycle.
  // A request wins over an ERET, and the ERET is squashed.
  always_comb begin
    w_next      = r_state;
    w_flush     = 1'b0;
    w_take_req  = 1'b0;
    w_take_eret = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_in) begin
          w_take_req = 1'b1;
          w_flush    = 1'b1;
          w_next     = S_TRAP;
        end else if (eret_m && !stall_in) begin
          w_take_eret = 1'b1;
          w_flush     = 1'b1;
          w_next      = S_RET;
        end
      end
      S_TRAP, S_RET: begin
        w_flush = 1'b1;
        if (fetch_ready) begin
          w_accept = 1'b1;
          w_next   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The count is loaded with DRAIN_CYC on entry. Leaving on 1 gives
        // exactly DRAIN_CYC cycles here. A count of 0 also exits, as a guard.
        if (r_drain <= 4'd1) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Return target is captured only when the ERET is actually taken
  always_ff @(posedge clk) begin
    if (reset)            r_target <= 32'd0;
    else if (w_take_eret) r_target <= epc_in;
  end

  // Drain counter: loaded when fetch accepts the redirect, counts down in DRAIN
  always_ff @(posedge clk) begin
    if (reset)                                  r_drain <= 4'd0;
    else if (w_accept)                          r_drain <= LP_DRAIN;
    else if (r_state == S_DRAIN && r_drain != 4'd0) r_drain <= r_drain - 4'd1;
  end

  // Saturating event counters, updated only on IDLE->TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_cnt <= '0;
      r_int_cnt <= '0;
    end else if (w_take_req) begin
      if (exc_code_m != 5'd0) begin
        if (!(&r_exc_cnt)) r_exc_cnt <= r_exc_cnt + LP_ONE;
      end else begin
        if (!(&r_int_cnt)) r_int_cnt <= r_int_cnt + LP_ONE;
      end
    end
  end

  // Output decode from the registered state
  always_comb begin
    redirect_pc = 32'd0;
    case (r_state)
      S_TRAP:  redirect_pc = HANDLER_ADDR;
      S_RET:   redirect_pc = r_target;
      default: redirect_pc = 32'd0;
    endcase
  end

  assign flush_fdem     = w_flush;
  assign redirect_valid = (r_state == S_TRAP) || (r_state == S_RET);
  assign busy           = (r_state != S_IDLE);
  assign state          = r_state;
  assign exc_cnt        = r_exc_cnt;
  assign int_cnt        = r_int_cnt;

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Pipeline-side controller for the CP0 exception/interrupt path in the five-stage MIPS core.
- On a CP0 request (Req) or a committing ERET in M, it flushes F/D/E/M and drives a PC redirect to the handler or the saved EPC.
- The redirect is held until fetch accepts it, then a programmable drain window follows.
- Keeps saturating counts of exceptions and interrupts taken.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
DRAIN_CYC, 1, cycles spent in DRAIN after redirect accepted (1..15)
CNT_W, 16, width of event counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_in  input  1  CP0 Req (interrupt or exception being committed this cycle)
exc_code_m  input  5  ExcCode presented to CP0 this cycle; 0 with req_in=1 means interrupt
eret_m  input  1  ERET in M stage
stall_in  input  1  hazard-unit stall; M instruction not committing
epc_in  input  32  CP0 EPC output
fetch_ready  input  1  IF accepts redirect this cycle
flush_fdem  output  1  clear F/D/E/M pipeline registers
redirect_valid  output  1  PC redirect request
redirect_pc  output  32  redirect target; 0 when redirect_valid=0
busy  output  1  state != IDLE
exc_cnt  output  CNT_W  exceptions taken, saturating
int_cnt  output  CNT_W  interrupts taken, saturating
state  output  2  IDLE=0, TRAP=1, RET=2, DRAIN=3

Behaviour:
- Reset (sync, active-high) puts state in IDLE. exc_cnt, int_cnt, the internal target register and the drain counter all go to 0. All outputs are 0.
- Reset asserted mid-sequence overrides everything: state is IDLE and redirect_valid=0 after that edge.

IDLE:
- If req_in=1, flush_fdem=1 combinationally in the same cycle, regardless of stall_in. Next state is TRAP.
- At that same edge, if exc_code_m!=0, exc_cnt increments by 1; otherwise int_cnt increments by 1.
- Otherwise, if eret_m=1 and stall_in=0, flush_fdem=1 combinationally. epc_in is latched into target and next state is RET.
- If eret_m=1 and stall_in=1, nothing happens; the ERET is taken on its first unstalled cycle.
- req_in has priority over eret_m when both are high. The ERET is squashed and no EPC is latched.
- In IDLE, redirect_valid=0 and busy=0.

TRAP:
- redirect_valid=1, redirect_pc=HANDLER_ADDR, flush_fdem=1.
- req_in and eret_m are ignored; no counter change.
- When fetch_ready=1, load the drain counter with DRAIN_CYC and go to DRAIN. Otherwise stay, holding outputs stable.

RET:
- Same as TRAP, except redirect_pc is the latched target. A later change on epc_in does not affect it.

DRAIN:
- redirect_valid=0, flush_fdem=0, busy=1.
- req_in and eret_m are ignored.
- The drain counter decrements each cycle. When it equals 1, the next state is IDLE.
- The DRAIN state therefore lasts exactly DRAIN_CYC cycles.

Counters:
- Counters saturate at all-ones; an increment at max holds the value.
- Counters change only on the IDLE->TRAP edge.

Outputs and transitions:
- state, busy and redirect_valid are decoded from registered state.
- flush_fdem is combinational from state and inputs (IDLE case only) plus registered state.
- Single-cycle fetch_ready in TRAP/RET is honoured: exactly one transfer, then DRAIN.
- Unused encodings are unreachable. If entered, the next state is IDLE.

Test Plan:
- Reset, then req_in=1 with exc_code_m=5'd4 in cycle 3 and fetch_ready=1 from cycle 5 -> flush_fdem=1 in cycles 3-5; redirect_valid=1 with redirect_pc=0x00004180 in cycles 4-5; DRAIN in cycle 6; IDLE in cycle 7; exc_cnt=1, int_cnt=0.
- req_in=1 with exc_code_m=0 and fetch_ready held low for 4 cycles -> state stays TRAP with redirect stable for 4 cycles, then DRAIN; int_cnt=1.
- eret_m=1 with epc_in=0x00003010 and stall_in=1 for 2 cycles, then stall_in=0 -> no flush during the stall; flush on the third cycle. Change epc_in to 0x0 in RET -> redirect_pc remains 0x00003010.
- req_in=1 and eret_m=1 in the same cycle -> next state TRAP, redirect_pc=0x00004180, target not loaded. A further req_in pulse during TRAP/DRAIN does not change the counters.
- DRAIN_CYC=3 build -> DRAIN lasts exactly 3 cycles. Preload 0xFFFE exceptions via a force, then take 2 exceptions -> exc_cnt=0xFFFF.
- Reset asserted while in RET with redirect_valid=1 -> after that edge state=IDLE, redirect_valid=0, counters=0.
